// File: rtl/cap_sensor_array.sv
// Round-robin capacitive pad scanner: charge-time measurement, per-channel baseline, hysteretic touch flags.
// Define CAP_BASELINE_TRACK_EN to let baselines of untouched pads follow slow drift.
module cap_sensor_array #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DIS_CYCLES  = 64,
  parameter int TIMEOUT     = 4095,
  parameter int THRESH_ON   = 40,
  parameter int THRESH_OFF  = 20,
  parameter int TRACK_SHIFT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sensor_in,
  output logic [NUM_CH-1:0] sensor_out,
  output logic [NUM_CH-1:0] touched,
  output logic [CNT_W-1:0]  count_out,
  output logic [3:0]        count_ch,
  output logic              count_valid
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [CNT_W:0] TH_ON  = (CNT_W+1)'(THRESH_ON);
  localparam logic signed [CNT_W:0] TH_OFF = (CNT_W+1)'(THRESH_OFF);
`ifdef CAP_BASELINE_TRACK_EN
  localparam bit TRACK_EN = 1'b1;
`else
  localparam bit TRACK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {DISCHARGE, CHARGE, EVAL} state_t;

  state_t             state;
  logic [CH_W-1:0]    ch;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   sample;
  logic [NUM_CH-1:0]  sync1, sync2;
  logic [CNT_W-1:0]   base [NUM_CH];
  logic [NUM_CH-1:0]  base_valid;

  logic signed [CNT_W:0] diff;
  logic                  timed_out;
  logic                  touch_next;
  logic [CNT_W-1:0]      base_tracked;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor_in;
      sync2 <= sync1;
    end
  end

  // Evaluation of the sample latched during CHARGE against the current channel's baseline.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    diff         = $signed({1'b0, sample}) - $signed({1'b0, base[ch]});
    timed_out    = (sample == CNT_W'(TIMEOUT));
    touch_next   = touched[ch];
    base_tracked = base[ch] + CNT_W'(diff >>> TRACK_SHIFT);
    if (timed_out || diff >= TH_ON)
      touch_next = 1'b1;
    else if (diff < TH_OFF)
      touch_next = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= DISCHARGE;
      ch          <= '0;
      cnt         <= '0;
      sample      <= '0;
      sensor_out  <= '0;
      touched     <= '0;
      count_out   <= '0;
      count_ch    <= '0;
      count_valid <= 1'b0;
      base_valid  <= '0;
      // NOTE: the baseline array is reset explicitly; an invalid baseline must also read as zero.
      for (int i = 0; i < NUM_CH; i++) base[i] <= '0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        DISCHARGE: begin
          if (cnt == CNT_W'(DIS_CYCLES - 1)) begin
            cnt        <= '0;
            sensor_out <= NUM_CH'(1) << ch;
            state      <= CHARGE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHARGE: begin
          // Counter saturates at TIMEOUT: the stuck-pad case exits here instead of wrapping.
          if (sync2[ch] || cnt == CNT_W'(TIMEOUT)) begin
            sample     <= cnt;
            sensor_out <= '0;
            state      <= EVAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EVAL: begin
          count_out   <= sample;
          count_ch    <= 4'(ch);
          count_valid <= 1'b1;
          cnt         <= '0;
          if (!base_valid[ch]) begin
            if (!timed_out) begin
              base[ch]       <= sample;
              base_valid[ch] <= 1'b1;
            end
          end else begin
            touched[ch] <= touch_next;
            if (TRACK_EN && !touch_next && !timed_out) base[ch] <= base_tracked;
          end
          ch    <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
          state <= DISCHARGE;
        end
        default: state <= DISCHARGE;
      endcase
    end
  end

endmodule

// File: tb/tb_cap_sensor_array.sv
// Self-checking bench for cap_sensor_array: RC pad model, vector table, corner sequences, random scan
// checked by a per-strobe reference model.
module tb_cap_sensor_array;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int DIS     = 64;
  localparam int TIMEOUT = 4095;
  localparam int TH_ON   = 40;
  localparam int TH_OFF  = 20;
  localparam int TSHIFT  = 4;
  localparam int STUCK   = 100000;
  localparam int LIMIT   = 6000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] sensor_in = '0;
  logic [NUM_CH-1:0] sensor_out;
  logic [NUM_CH-1:0] touched;
  logic [CNT_W-1:0]  count_out;
  logic [3:0]        count_ch;
  logic              count_valid;

  cap_sensor_array #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIS_CYCLES(DIS), .TIMEOUT(TIMEOUT),
    .THRESH_ON(TH_ON), .THRESH_OFF(TH_OFF), .TRACK_SHIFT(TSHIFT)
  ) dut (
    .clock(clock), .reset(reset), .sensor_in(sensor_in), .sensor_out(sensor_out),
    .touched(touched), .count_out(count_out), .count_ch(count_ch), .count_valid(count_valid)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Pad model: sense input rises D clocks after the drive rises, drops when drive drops.
  int dly[NUM_CH];
  int latched_d[NUM_CH];
  int hi[NUM_CH];

  always @(posedge clock) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sensor_out[c]) begin
        if (hi[c] == 0) latched_d[c] = dly[c];
        hi[c] = hi[c] + 1;
      end else begin
        hi[c] = 0;
      end
      sensor_in[c] = sensor_out[c] && (hi[c] > latched_d[c]);
    end
  end

  // Reference model: scan order, expected counts, baselines and touch flags in plain integers.
  int         m_base[NUM_CH];
  bit         m_valid[NUM_CH];
  logic [3:0] m_touch;
  int         m_ch;
  int         since;
  bit         have_prev;
  int         mon_cnt;
  int         mon_diff;

  function automatic int exp_count(int d);
    return (d + 2 > TIMEOUT) ? TIMEOUT : d + 2;
  endfunction

  task automatic model_reset();
    m_ch      = 0;
    m_touch   = '0;
    have_prev = 1'b0;
    since     = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_base[c]  = 0;
      m_valid[c] = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      since++;
      check("drive_onehot", $countones(sensor_out) <= 1, 1);
      if (count_valid) begin
        mon_cnt = exp_count(latched_d[m_ch]);
        check("strobe_ch", count_ch, m_ch);
        check("strobe_count", count_out, mon_cnt);
        if (have_prev) check("strobe_spacing", since, DIS + mon_cnt + 2);
        if (!m_valid[m_ch]) begin
          if (mon_cnt < TIMEOUT) begin
            m_base[m_ch]  = mon_cnt;
            m_valid[m_ch] = 1'b1;
          end
        end else begin
          mon_diff = mon_cnt - m_base[m_ch];
          if (mon_cnt == TIMEOUT || mon_diff >= TH_ON) m_touch[m_ch] = 1'b1;
          else if (mon_diff < TH_OFF)                  m_touch[m_ch] = 1'b0;
`ifdef CAP_BASELINE_TRACK_EN
          if (!m_touch[m_ch] && mon_cnt < TIMEOUT)
            m_base[m_ch] = (m_base[m_ch] + (mon_diff >>> TSHIFT)) & 16'hFFFF;
`endif
        end
        m_ch      = (m_ch + 1) % NUM_CH;
        since     = 0;
        have_prev = 1'b1;
      end
      check("touched_model", touched, m_touch);
    end
  end

  task automatic wait_strobe();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!count_valid && n < LIMIT);
    if (!count_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_timeout: no count_valid within %0d cycles", LIMIT);
    end
  endtask

  task automatic wait_ch(int c);
    int tries = 0;
    do begin
      wait_strobe();
      tries++;
    end while (count_ch != 4'(c) && tries < NUM_CH + 1);
    check("wait_ch", count_ch, c);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0][19:0] d;
    logic [3:0][15:0] cnt;
    logic [3:0]       touch;
  } vec_t;

  function automatic vec_t mk(int d0, int d1, int d2, int d3,
                              int c0, int c1, int c2, int c3, logic [3:0] t);
    vec_t v;
    v.d[0] = 20'(d0); v.d[1] = 20'(d1); v.d[2] = 20'(d2); v.d[3] = 20'(d3);
    v.cnt[0] = 16'(c0); v.cnt[1] = 16'(c1); v.cnt[2] = 16'(c2); v.cnt[3] = 16'(c3);
    v.touch = t;
    return v;
  endfunction

  vec_t tbl[10];
  int   n_wait;

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rounds start right after reset, so all baselines come from the first row (102).
    tbl[0] = mk(100, 100, 100, 100,   102, 102, 102, 102,  4'b0000);
    tbl[1] = mk(100, 100, 140, 100,   102, 102, 142, 102,  4'b0100);
    tbl[2] = mk(100, 100, 123, 100,   102, 102, 125, 102,  4'b0100);
    tbl[3] = mk(100, 100, 113, 100,   102, 102, 115, 102,  4'b0000);
    tbl[4] = mk(100, 100, 139, 100,   102, 102, 141, 102,  4'b0000);
    tbl[5] = mk(140, 100, 100,  50,   142, 102, 102,  52,  4'b0001);
    tbl[6] = mk(120, 100, 100, 100,   122, 102, 102, 102,  4'b0001);
    tbl[7] = mk(119, 100, 100, 100,   121, 102, 102, 102,  4'b0000);
    tbl[8] = mk(100, 100, 100, STUCK, 102, 102, 102, 4095, 4'b1000);
    tbl[9] = mk(100, 100, 100, 100,   102, 102, 102, 102,  4'b0000);

    for (int c = 0; c < NUM_CH; c++) dly[c] = 100;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_sensor_out", sensor_out, 0);
    check("rst_touched", touched, 0);
    check("rst_count_out", count_out, 0);
    check("rst_count_ch", count_ch, 0);
    check("rst_count_valid", count_valid, 0);
    reset = 1'b0;

    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < NUM_CH; c++) dly[c] = int'(tbl[r].d[c]);
      for (int c = 0; c < NUM_CH; c++) begin
        wait_strobe();
        check($sformatf("vec%0d_ch%0d_id", r, c), count_ch, c);
        check($sformatf("vec%0d_ch%0d_count", r, c), count_out, tbl[r].cnt[c]);
      end
      check($sformatf("vec%0d_touched", r), touched, tbl[r].touch);
    end

    // Channel 1 stuck low from reset: never initialises a baseline until it finally responds.
    dly[0] = 100; dly[1] = STUCK; dly[2] = 100; dly[3] = 100;
    do_reset();
    wait_ch(1);
    check("stuck_count_a", count_out, 4095);
    check("stuck_touch_a", touched[1], 0);
    wait_ch(1);
    check("stuck_count_b", count_out, 4095);
    check("stuck_touch_b", touched[1], 0);
    dly[1] = 100;
    wait_ch(1);
    check("release_count", count_out, 102);
    check("release_touch", touched[1], 0);
    dly[1] = 140;
    wait_ch(1);
    check("release_press_count", count_out, 142);
    check("release_press_touch", touched[1], 1);

    // Reset in the middle of channel 3's charge phase.
    for (int c = 0; c < NUM_CH; c++) dly[c] = 100;
    n_wait = 0;
    do begin
      @(negedge clock);
      n_wait++;
    end while (!sensor_out[3] && n_wait < 4 * LIMIT);
    check("midcharge_drive_seen", sensor_out, 4'b1000);
    repeat (20) @(posedge clock);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_sensor_out", sensor_out, 0);
    check("midrst_touched", touched, 0);
    check("midrst_count_out", count_out, 0);
    check("midrst_count_ch", count_ch, 0);
    check("midrst_count_valid", count_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_strobe();
    check("midrst_next_ch", count_ch, 0);
    check("midrst_next_count", count_out, 102);
    check("midrst_next_touch", touched, 0);

    // Random pad delays, one channel retuned after every strobe, checked by the model.
    for (int i = 0; i < 48; i++) begin
      wait_strobe();
      dly[$urandom_range(0, NUM_CH - 1)] =
        ($urandom_range(0, 15) == 0) ? STUCK : int'($urandom_range(60, 200));
    end
    wait_strobe();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
